mmu_region_translator: RTL and testbench

Parametrised, pipelined successor to the fixed three-window MMU: it translates virtual addresses into (region, physical offset) for NUM_REGIONS programmable windows. Each window can grow upward (data/MMIO style) or downward (stack style). Requests and responses use valid/ready handshakes with a registered output stage. Misses are reported as faults and captured in a sticky fault register. It sits between the CPU load/store path and the data, stack and MMIO memory blocks.

---
 rtl/mmu_pkg.sv | 31 +++
 rtl/mmu_region_match.sv | 31 +++
 rtl/mmu_region_translator.sv | 136 +++++++++++++
 tb/tb_mmu_region_translator.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmu_pkg.sv
// Shared types and reset-map constants for the region translator.
// Descriptor base width is fixed at MMU_ADDR_W; the translator's ADDR_W must match it.
package mmu_pkg;

  localparam int MMU_ADDR_W = 16;

  localparam logic [MMU_ADDR_W-1:0] RST_DATA_BASE  = 16'h2000;
  localparam logic [MMU_ADDR_W-1:0] RST_STACK_BASE = 16'h3FFC;
  localparam logic [MMU_ADDR_W-1:0] RST_MMIO_BASE  = 16'h7F00;

  typedef struct packed {
    logic [MMU_ADDR_W-1:0] base;
    logic                  down;
    logic                  en;
    logic                  ro;
  } region_desc_t;

  // Power-up descriptor for a given region index: data, stack, MMIO, then disabled.
  function automatic region_desc_t rst_desc(input int idx);
    region_desc_t d;
    d = '0;
    case (idx)
      0: begin d.base = RST_DATA_BASE;  d.en = 1'b1; end
      1: begin d.base = RST_STACK_BASE; d.en = 1'b1; d.down = 1'b1; end
      2: begin d.base = RST_MMIO_BASE;  d.en = 1'b1; end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mmu_region_match.sv
// Combinational hit test and offset computation for a single window descriptor.
// Differences use one extra bit so the borrow flags addresses outside the window.
module mmu_region_match
  import mmu_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int BLOCK_SIZE = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  region_desc_t      desc,
  output logic              hit,
  output logic [ADDR_W-1:0] phys
);

  logic [ADDR_W:0] diff;
  logic            unused_ro;

  assign unused_ro = desc.ro;

  always_comb begin
    if (desc.down) begin
      diff = {1'b0, desc.base} - {1'b0, addr};
    end else begin
      diff = {1'b0, addr} - {1'b0, desc.base};
    end
    // A set top bit means the subtraction borrowed: the address lies on the wrong side of base.
    hit  = desc.en && !diff[ADDR_W] && (diff < (ADDR_W+1)'(BLOCK_SIZE));
    phys = diff[ADDR_W-1:0];
  end

endmodule

// File: rtl/mmu_region_translator.sv
// Pipelined virtual-to-(region, offset) translator with programmable windows and sticky fault capture.
// Optional write protection is compiled in with MMU_WRITE_PROTECT_EN.
module mmu_region_translator
  import mmu_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int NUM_REGIONS = 4,
  parameter int BLOCK_SIZE  = 32,
  parameter int IDX_W       = $clog2(NUM_REGIONS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic              cfg_down,
  input  logic              cfg_en,
  input  logic              cfg_ro,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDX_W-1:0]  rsp_region,
  output logic [ADDR_W-1:0] rsp_phys,
  output logic              rsp_fault,
  output logic              fault_flag,
  output logic [ADDR_W-1:0] fault_addr,
  input  logic              fault_clear
);

  logic [NUM_REGIONS-1:0]             hit;
  logic [NUM_REGIONS-1:0]             ro_all;
  logic [NUM_REGIONS-1:0][ADDR_W-1:0] phys_all;

  logic              sel_hit;
  logic              sel_ro;
  logic [IDX_W-1:0]  sel_idx;
  logic [ADDR_W-1:0] sel_phys;
  logic              sel_fault;
  logic              accept;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGIONS; gi++) begin : g_region
      region_desc_t desc_reg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          desc_reg <= rst_desc(gi);
        end else if (cfg_we && cfg_idx == IDX_W'(gi)) begin
          desc_reg.base <= cfg_base;
          desc_reg.down <= cfg_down;
          desc_reg.en   <= cfg_en;
`ifdef MMU_WRITE_PROTECT_EN
          desc_reg.ro   <= cfg_ro;
`else
          desc_reg.ro   <= 1'b0;
`endif
        end
      end

      assign ro_all[gi] = desc_reg.ro;

      mmu_region_match #(
        .ADDR_W     (ADDR_W),
        .BLOCK_SIZE (BLOCK_SIZE)
      ) u_match (
        .addr (req_addr),
        .desc (desc_reg),
        .hit  (hit[gi]),
        .phys (phys_all[gi])
      );
    end
  endgenerate

  // Scan from the top down so the lowest matching index is the last one assigned.
  always_comb begin
    sel_hit  = 1'b0;
    sel_ro   = 1'b0;
    sel_idx  = '0;
    sel_phys = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        sel_hit  = 1'b1;
        sel_ro   = ro_all[i];
        sel_idx  = IDX_W'(i);
        sel_phys = phys_all[i];
      end
    end
  end

`ifdef MMU_WRITE_PROTECT_EN
  assign sel_fault = !sel_hit || (req_write && sel_ro);
`else
  logic unused_wp;
  assign unused_wp = &{1'b0, cfg_ro, req_write, sel_ro};
  assign sel_fault = !sel_hit;
`endif

  assign req_ready = !rsp_valid || rsp_ready;
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid  <= 1'b0;
      rsp_region <= '0;
      rsp_phys   <= '0;
      rsp_fault  <= 1'b0;
    end else if (accept) begin
      rsp_valid  <= 1'b1;
      rsp_region <= sel_idx;
      rsp_phys   <= sel_phys;
      rsp_fault  <= sel_fault;
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

  // A new fault outranks a simultaneous clear and then records its own address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault_flag <= 1'b0;
      fault_addr <= '0;
    end else if (accept && sel_fault) begin
      fault_flag <= 1'b1;
      if (!fault_flag || fault_clear) begin
        fault_addr <= req_addr;
      end
    end else if (fault_clear) begin
      fault_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mmu_region_translator.sv
// Randomized and directed bench for mmu_region_translator against a transaction-level window model.
// Build with MMU_WRITE_PROTECT_EN to also exercise write protection.
module tb_mmu_region_translator;

  localparam int ADDR_W = 16;
  localparam int NR     = 4;
  localparam int BS     = 32;
  localparam int IDX_W  = 2;
`ifdef MMU_WRITE_PROTECT_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic              cfg_we;
  logic [IDX_W-1:0]  cfg_idx;
  logic [ADDR_W-1:0] cfg_base;
  logic              cfg_down;
  logic              cfg_en;
  logic              cfg_ro;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_write;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDX_W-1:0]  rsp_region;
  logic [ADDR_W-1:0] rsp_phys;
  logic              rsp_fault;
  logic              fault_flag;
  logic [ADDR_W-1:0] fault_addr;
  logic              fault_clear;

  mmu_region_translator #(
    .ADDR_W      (ADDR_W),
    .NUM_REGIONS (NR),
    .BLOCK_SIZE  (BS),
    .IDX_W       (IDX_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_we      (cfg_we),
    .cfg_idx     (cfg_idx),
    .cfg_base    (cfg_base),
    .cfg_down    (cfg_down),
    .cfg_en      (cfg_en),
    .cfg_ro      (cfg_ro),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_write   (req_write),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_region  (rsp_region),
    .rsp_phys    (rsp_phys),
    .rsp_fault   (rsp_fault),
    .fault_flag  (fault_flag),
    .fault_addr  (fault_addr),
    .fault_clear (fault_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: window table plus the expected visible outputs.
  int m_base [NR];
  bit m_down [NR];
  bit m_en   [NR];
  bit m_ro   [NR];
  bit e_valid;
  bit e_fault;
  bit e_flag;
  int e_region;
  int e_phys;
  int e_faddr;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_base[i] = 0; m_down[i] = 0; m_en[i] = 0; m_ro[i] = 0;
    end
    m_base[0] = 'h2000; m_en[0] = 1;
    m_base[1] = 'h3FFC; m_en[1] = 1; m_down[1] = 1;
    m_base[2] = 'h7F00; m_en[2] = 1;
    e_valid = 0; e_fault = 0; e_flag = 0;
    e_region = 0; e_phys = 0; e_faddr = 0;
  endtask

  // Windows as plain integer ranges; first enabled window containing the address wins.
  task automatic translate(input int addr, input bit wr, output int r, output int p, output bit f);
    r = 0; p = 0; f = 1;
    for (int i = 0; i < NR; i++) begin
      if (m_en[i]) begin
        int d;
        d = m_down[i] ? (m_base[i] - addr) : (addr - m_base[i]);
        if (d >= 0 && d < BS) begin
          r = i; p = d; f = (WP && wr && m_ro[i]);
          break;
        end
      end
    end
  endtask

  task automatic model_step();
    bit acc;
    bit tf;
    int tr;
    int tp;
    if (reset) begin
      model_reset();
      return;
    end
    acc = req_valid && (!e_valid || rsp_ready);
    tf = 0; tr = 0; tp = 0;
    if (acc) begin
      translate(int'(req_addr), req_write, tr, tp, tf);
      $display("txn addr=%h wr=%b -> region=%0d phys=%0d fault=%0b", req_addr, req_write, tr, tp, tf);
    end
    if (acc && tf) begin
      if (!e_flag || fault_clear) e_faddr = int'(req_addr);
      e_flag = 1;
    end else if (fault_clear) begin
      e_flag = 0;
    end
    if (acc) begin
      e_valid = 1; e_region = tr; e_phys = tp; e_fault = tf;
    end else if (rsp_ready) begin
      e_valid = 0;
    end
    if (cfg_we && int'(cfg_idx) < NR) begin
      m_base[cfg_idx] = int'(cfg_base);
      m_down[cfg_idx] = cfg_down;
      m_en[cfg_idx]   = cfg_en;
      m_ro[cfg_idx]   = WP ? cfg_ro : 1'b0;
    end
  endtask

  task automatic compare();
    chk("rsp_valid", 32'(rsp_valid), 32'(e_valid));
    chk("req_ready", 32'(req_ready), 32'(!e_valid || rsp_ready));
    if (e_valid) begin
      chk("rsp_region", 32'(rsp_region), e_region);
      chk("rsp_phys", 32'(rsp_phys), e_phys);
      chk("rsp_fault", 32'(rsp_fault), 32'(e_fault));
    end
    chk("fault_flag", 32'(fault_flag), 32'(e_flag));
    chk("fault_addr", 32'(fault_addr), e_faddr);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic do_req(input logic [15:0] a, input logic w);
    req_valid = 1; req_addr = a; req_write = w;
    cycle();
    req_valid = 0; req_write = 0;
  endtask

  task automatic lit(input string name, input int r, input int p, input int f);
    chk({name, "_valid"}, 32'(rsp_valid), 1);
    chk({name, "_region"}, 32'(rsp_region), r);
    chk({name, "_phys"}, 32'(rsp_phys), p);
    chk({name, "_fault"}, 32'(rsp_fault), f);
  endtask

  task automatic cfg(input int idx, input logic [15:0] b, input bit dn, input bit en, input bit ro);
    cfg_we = 1; cfg_idx = IDX_W'(idx); cfg_base = b; cfg_down = dn; cfg_en = en; cfg_ro = ro;
    cycle();
    cfg_we = 0;
  endtask

  task automatic pulse_clear();
    fault_clear = 1;
    cycle();
    fault_clear = 0;
  endtask

  initial begin
    cfg_we = 0; cfg_idx = '0; cfg_base = '0; cfg_down = 0; cfg_en = 0; cfg_ro = 0;
    req_valid = 0; req_addr = '0; req_write = 0; rsp_ready = 1; fault_clear = 0;
    model_reset();
    reset = 1;
    repeat (2) cycle();
    reset = 0;
    cycle();
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_fault", 32'(rsp_fault), 0);
    chk("rst_rsp_region", 32'(rsp_region), 0);
    chk("rst_rsp_phys", 32'(rsp_phys), 0);
    chk("rst_fault_flag", 32'(fault_flag), 0);
    chk("rst_fault_addr", 32'(fault_addr), 0);

    do_req(16'h2005, 0); lit("rd2005", 0, 5, 0);
    do_req(16'h3FF0, 0); lit("rd3FF0", 1, 12, 0);
    do_req(16'h7F1F, 0); lit("rd7F1F", 2, 31, 0);

    do_req(16'h2020, 0); lit("rd2020", 0, 0, 1);
    chk("faddr2020", 32'(fault_addr), 'h2020);
    do_req(16'h3FDC, 0); lit("rd3FDC", 0, 0, 1);
    do_req(16'h3FDD, 0); lit("rd3FDD", 1, 31, 0);
    pulse_clear();
    chk("cleared_flag", 32'(fault_flag), 0);
    do_req(16'h1FFF, 0); lit("rd1FFF", 0, 0, 1);
    chk("faddr1FFF", 32'(fault_addr), 'h1FFF);

    cfg(3, 16'h2010, 0, 1, 0);
    do_req(16'h2012, 0); lit("prio", 0, 18, 0);
    cfg(0, 16'h2000, 0, 0, 0);
    do_req(16'h2012, 0); lit("r3only", 3, 2, 0);
    cfg(0, 16'h2000, 0, 1, 0);
    // Descriptor write coinciding with an accept: the request sees the old table.
    cfg_we = 1; cfg_idx = 0; cfg_base = 16'h2000; cfg_down = 0; cfg_en = 0; cfg_ro = 0;
    do_req(16'h2012, 0); cfg_we = 0;
    lit("cfg_same_cycle", 0, 18, 0);
    do_req(16'h2012, 0); lit("cfg_next_cycle", 3, 2, 0);
    cfg(0, 16'h2000, 0, 1, 0);

    cycle();
    rsp_ready = 0; req_valid = 1; req_addr = 16'h2003;
    cycle();
    lit("stall_first", 0, 3, 0);
    req_addr = 16'h7F10;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_ready", 32'(req_ready), 0);
      lit("stall_hold", 0, 3, 0);
    end
    rsp_ready = 1;
    cycle();
    lit("stall_release", 2, 16, 0);
    req_valid = 0;
    cycle();

    pulse_clear();
    do_req(16'h0000, 0);
    do_req(16'hFFFF, 0); lit("rdFFFF", 0, 0, 1);
    chk("faddr_first", 32'(fault_addr), 0);
    fault_clear = 1;
    do_req(16'h5000, 0);
    fault_clear = 0;
    chk("clr_vs_fault_flag", 32'(fault_flag), 1);
    chk("clr_vs_fault_addr", 32'(fault_addr), 'h5000);

`ifdef MMU_WRITE_PROTECT_EN
    cfg(2, 16'h7F00, 0, 1, 1);
    do_req(16'h7F04, 1); lit("wp_write", 2, 4, 1);
    do_req(16'h7F04, 0); lit("wp_read", 2, 4, 0);
    cfg(2, 16'h7F00, 0, 1, 0);
`else
    do_req(16'h7F04, 1); lit("nowp_write", 2, 4, 0);
`endif

    // Reset while a response is stalled must discard it.
    rsp_ready = 0;
    do_req(16'h2001, 0);
    reset = 1;
    cycle();
    reset = 0; rsp_ready = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("post_reset_idle", 32'(rsp_valid), 0);
    end
    do_req(16'h3FF0, 0); lit("post_reset_map", 1, 12, 0);

    for (int n = 0; n < 1500; n++) begin
      int pick;
      req_valid   = ($urandom_range(0, 3) != 0);
      req_write   = $urandom_range(0, 1);
      rsp_ready   = ($urandom_range(0, 3) != 0);
      fault_clear = ($urandom_range(0, 15) == 0);
      pick = $urandom_range(0, NR);
      if (pick < NR)
        req_addr = 16'(m_base[pick] + $urandom_range(0, 80) - 40);
      else
        req_addr = 16'($urandom);
      cfg_we = ($urandom_range(0, 31) == 0);
      cfg_idx = IDX_W'($urandom_range(0, NR - 1));
      cfg_base = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 40)) :
                 ($urandom_range(0, 2) == 0) ? 16'(16'hFFFF - $urandom_range(0, 40)) : 16'($urandom);
      cfg_down = $urandom_range(0, 1);
      cfg_en   = ($urandom_range(0, 3) != 0);
      cfg_ro   = $urandom_range(0, 1);
      cycle();
    end
    req_valid = 0; cfg_we = 0; fault_clear = 0; rsp_ready = 1;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
